// File: rtl/fetch_queue_unit.sv
// PC generator and fetched-instruction queue. Issues sequential imem requests under a credit
// limit and queues {pc, instr} for decode; redirects flush the queue and drop stale responses.
module fetch_queue_unit #(
  parameter int WORD_W      = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int MAX_OUTST   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] reset_pc,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [WORD_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [WORD_W-1:0] imem_rsp_data,
  output logic              fetch_valid,
  output logic [WORD_W-1:0] fetch_pc,
  output logic [WORD_W-1:0] fetch_instr,
  input  logic              decode_ready
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int OW = $clog2(MAX_OUTST) + 1;
  localparam int FW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  logic [WORD_W-1:0] pc;
  logic [OW-1:0]     outst, discard;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [FW-1:0]     if_rd, if_wr;
  fetch_entry_t      queue [QUEUE_DEPTH];
  logic [WORD_W-1:0] inflight_pc [MAX_OUTST];
  logic              accept, drop, push, pop;

  // Credit rule: in-flight plus queued never exceeds depth, so responses always have a slot.
  assign imem_req_valid = !reset && !redirect_valid && (int'(outst) < MAX_OUTST) &&
                          (int'(outst) + int'(count) < QUEUE_DEPTH);
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign drop           = imem_rsp_valid && (redirect_valid || discard != '0);
  assign push           = imem_rsp_valid && !drop;
  assign pop            = fetch_valid && decode_ready && !redirect_valid;

  assign fetch_valid    = (count != '0);
  assign fetch_pc       = queue[rd_ptr].pc;
  assign fetch_instr    = queue[rd_ptr].instr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= reset_pc;
      outst   <= '0;
      discard <= '0;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      if_rd   <= '0;
      if_wr   <= '0;
    end else begin
      outst <= outst + OW'(accept) - OW'(imem_rsp_valid);
      if (accept) begin
        pc    <= pc + WORD_W'(4);
        if_wr <= (if_wr == FW'(MAX_OUTST - 1)) ? '0 : if_wr + FW'(1);
      end
      // The PC FIFO pops on every response, dropped or not, to stay aligned with memory order.
      if (imem_rsp_valid)
        if_rd <= (if_rd == FW'(MAX_OUTST - 1)) ? '0 : if_rd + FW'(1);
      if (redirect_valid) begin
        pc      <= redirect_pc;
        // Every request still in flight after this cycle belongs to the abandoned stream.
        discard <= outst - OW'(imem_rsp_valid);
        count   <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
      end else begin
        if (drop) discard <= discard - OW'(1);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) queue[i] <= '0;
    end else if (push) begin
      queue[wr_ptr] <= '{pc: inflight_pc[if_rd], instr: imem_rsp_data};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) inflight_pc[if_wr] <= pc;
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(imem_rsp_valid && outst == '0));
      assert (count <= CW'(QUEUE_DEPTH));
    end
  end
endmodule
